sd_spi_slave_byte_transfer: RTL and testbench
=============================================

SD_SPI_SLAVE_BYTE_TRANSFER -- requirements
Module: sd_spi_slave_byte_transfer

Interface
REQ-001 Parameter: SYNC_STAGES, 2, number of synchroniser flops on spi_sck_p, spi_ss_n_p and spi_mosi_p (legal values 2..3).
REQ-002 Parameter: FILL_BYTE, 8'hFF, byte shifted out when no transmit byte is loaded.
REQ-003 clk210_p  in  1  210 MHz system clock; the block uses one clock.
REQ-004 reset_n_p  in  1  reset, asynchronous, active-low.
REQ-005 spi_sck_p  in  1  external SPI clock, asynchronous to clk210_p, SPI mode 0 (idle low).
REQ-006 spi_ss_n_p  in  1  slave select, active-low, asynchronous.
REQ-007 spi_mosi_p  in  1  serial data from the master.
REQ-008 spi_miso_p  out  1  serial data to the master, MSB first.
REQ-009 spi_miso_oe_p  out  1  MISO drive enable, high only while selected.
REQ-010 tx_data_p  in  8  byte to return to the master.
REQ-011 tx_load_p  in  1  one-cycle strobe that writes tx_data_p into the holding register.
REQ-012 tx_ready_p  out  1  holding register empty.
REQ-013 rx_data_p  out  8  last complete byte received.
REQ-014 rx_valid_p  out  1  one-cycle pulse: rx_data_p updated.
REQ-015 tx_underrun_p  out  1  one-cycle pulse: FILL_BYTE substituted for an empty holding register.
REQ-016 busy_p  out  1  high while the FSM is in SHIFT.

Function
REQ-017 The block SHALL pass spi_sck_p, spi_ss_n_p and spi_mosi_p through SYNC_STAGES flops each, then detect SCK rise and fall edges on the synchronised SCK.
REQ-018 The block SHALL support SCK frequencies up to clk210_p/8 (26.25 MHz); faster SCK is out of scope.
REQ-019 The FSM SHALL have two states: IDLE and SHIFT.
REQ-020 IDLE -> SHIFT on the synchronised SS falling edge: load the TX shift register from the holding register (or FILL_BYTE if it is empty), clear the 3-bit bit counter, and set spi_miso_oe_p=1 and spi_miso_p=bit7 in the following cycle.
REQ-021 In SHIFT, on a synchronised SCK rise: shift the synchronised MOSI into the RX shift register LSB and increment the counter modulo 8.
REQ-022 When the counter wraps from 7 to 0: update rx_data_p with the full byte and pulse rx_valid_p for exactly one cycle, in the cycle after the edge detect.
REQ-023 In SHIFT, on a synchronised SCK fall: if counter!=0, shift the TX register left and present the new bit7 on MISO; if counter==0, reload from the holding register (or FILL_BYTE) and present bit7 of the new byte.
REQ-024 Each reload from the holding register SHALL set tx_ready_p=1; each FILL_BYTE substitution SHALL pulse tx_underrun_p.
REQ-025 tx_load_p while tx_ready_p=1 SHALL latch tx_data_p and clear tx_ready_p on the next cycle.
REQ-026 tx_load_p while tx_ready_p=0 SHALL be ignored and the held byte kept.
REQ-027 When tx_load_p coincides with a reload from an empty holding register: FILL_BYTE is sent, tx_underrun_p pulses, and tx_data_p is latched for the next byte.
REQ-028 A synchronised SS rise in SHIFT SHALL move the FSM to IDLE with these effects:
  - the partial byte is discarded and rx_valid_p is not asserted;
  - the counter is cleared;
  - spi_miso_oe_p=0 and spi_miso_p=1;
  - the holding register is preserved.
REQ-029 When an SS rise and an SCK edge are detected in the same cycle, the SS rise SHALL take priority.
REQ-030 rx_data_p SHALL hold its value until the next completed byte; there is no RX backpressure.

Reset
REQ-031 While reset_n_p=0 all outputs SHALL take their reset values:
  - spi_miso_p=1, spi_miso_oe_p=0;
  - tx_ready_p=1, busy_p=0;
  - rx_data_p=8'h00, rx_valid_p=0, tx_underrun_p=0.
REQ-032 While reset_n_p=0 the FSM SHALL be in IDLE and all shift registers, counters, the holding register and the synchronisers SHALL be cleared; synchroniser flops reset to 1 for SS and 0 for SCK.
REQ-033 Reset asserted mid-byte SHALL abort the transfer immediately, with no rx_valid_p pulse.

Structure
REQ-034 The shared package sd_spi_pkg SHALL hold the FSM state typedef (IDLE, SHIFT), the default FILL_BYTE and the default SYNC_STAGES.
REQ-035 One sub-module, sd_spi_sync (a parameterised N-flop synchroniser with a reset value), SHALL be instantiated three times.

Verification
REQ-036 Load tx 8'hA5; SS low; master sends 8'h3C at 5 MHz -> master reads 8'hA5, rx_data_p=8'h3C with one rx_valid_p pulse, tx_ready_p=1 after the first falling load.
REQ-037 No tx load; master clocks 2 bytes 8'h12, 8'h34 -> MISO returns 8'hFF twice, two tx_underrun_p pulses, rx_valid_p pulses with 8'h12 then 8'h34.
REQ-038 Load 8'h81, then tx_load_p 8'h55 while not ready -> 8'h55 ignored and 8'h81 is sent.
REQ-039 SS raised after 4 SCK rises -> no rx_valid_p, spi_miso_oe_p=0, busy_p=0; the next transfer starts at bit7.
REQ-040 reset_n_p pulsed low mid-byte at 26.25 MHz SCK -> all outputs at reset values asynchronously; a subsequent 8'hC3 transfer is received correctly.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD-card SPI slave byte transfer block.
// Holds the FSM state type and the default parameter values.
package sd_spi_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

    localparam logic [7:0]  DEFAULT_FILL_BYTE   = 8'hFF;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;
    localparam int unsigned BYTE_W              = 8;
    localparam int unsigned CNT_W               = 3;

endpackage : sd_spi_pkg

// File: rtl/sd_spi_sync.sv
// N-flop synchroniser for a single asynchronous input with a selectable
// reset value.
//   clk, rst_n : system clock, async active-low reset
//   d_i        : asynchronous input
//   q_o        : synchronised output (STAGES clocks of latency)
module sd_spi_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the input through the chain, oldest sample at the MSB.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : sd_spi_sync

// File: rtl/sd_spi_slave_byte_transfer.sv
// SPI mode-0 slave byte engine clocked by the system clock. SCK, SS and MOSI
// are synchronised and edge-detected; received bytes are presented on
// rx_data_p with a one-cycle rx_valid_p, and transmit bytes come from a
// single holding register (FILL_BYTE is substituted when it is empty).
//   clk210_p, reset_n_p          : system clock, async active-low reset
//   spi_sck_p/ss_n_p/mosi_p      : asynchronous SPI master signals
//   spi_miso_p, spi_miso_oe_p    : serial data out and its drive enable
//   tx_data_p, tx_load_p         : holding-register write port
//   tx_ready_p                   : holding register empty
//   rx_data_p, rx_valid_p        : last received byte and update strobe
//   tx_underrun_p                : FILL_BYTE substituted for an empty holder
//   busy_p                       : transfer in progress (SHIFT state)
module sd_spi_slave_byte_transfer
    import sd_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter logic [7:0]  FILL_BYTE   = DEFAULT_FILL_BYTE
) (
    input  logic              clk210_p,
    input  logic              reset_n_p,
    input  logic              spi_sck_p,
    input  logic              spi_ss_n_p,
    input  logic              spi_mosi_p,
    output logic              spi_miso_p,
    output logic              spi_miso_oe_p,
    input  logic [BYTE_W-1:0] tx_data_p,
    input  logic              tx_load_p,
    output logic              tx_ready_p,
    output logic [BYTE_W-1:0] rx_data_p,
    output logic              rx_valid_p,
    output logic              tx_underrun_p,
    output logic              busy_p
);

    logic sck_s;
    logic ss_n_s;
    logic mosi_s;

    sd_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk   (clk210_p),
        .rst_n (reset_n_p),
        .d_i   (spi_sck_p),
        .q_o   (sck_s)
    );

    sd_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk   (clk210_p),
        .rst_n (reset_n_p),
        .d_i   (spi_ss_n_p),
        .q_o   (ss_n_s)
    );

    sd_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (clk210_p),
        .rst_n (reset_n_p),
        .d_i   (spi_mosi_p),
        .q_o   (mosi_s)
    );

    spi_state_e        state_q,     state_d;
    logic              sck_prev_q,  sck_prev_d;
    logic              ss_prev_q,   ss_prev_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [6:0]        rx_shift_q,  rx_shift_d;
    // Bits still to be sent after the one currently on MISO.
    logic [6:0]        tx_shift_q,  tx_shift_d;
    logic [BYTE_W-1:0] hold_q,      hold_d;
    logic              tx_ready_q,  tx_ready_d;
    logic [BYTE_W-1:0] rx_data_q,   rx_data_d;
    logic              rx_valid_q,  rx_valid_d;
    logic              underrun_q,  underrun_d;
    logic              miso_q,      miso_d;
    logic              miso_oe_q,   miso_oe_d;

    logic              sck_rise_c;
    logic              sck_fall_c;
    logic              ss_fall_c;
    logic              ss_rise_c;
    logic              reload_c;
    logic [BYTE_W-1:0] next_byte_c;

    assign sck_rise_c = sck_s & ~sck_prev_q;
    assign sck_fall_c = ~sck_s & sck_prev_q;
    assign ss_fall_c  = ~ss_n_s & ss_prev_q;
    assign ss_rise_c  = ss_n_s & ~ss_prev_q;

    // Next-state, shift and holding-register logic.
    always_comb begin
        state_d     = state_q;
        sck_prev_d  = sck_s;
        ss_prev_d   = ss_n_s;
        cnt_d       = cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        tx_ready_d  = tx_ready_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        reload_c    = 1'b0;
        next_byte_c = FILL_BYTE;

        case (state_q)
            ST_IDLE: begin
                miso_d    = 1'b1;
                miso_oe_d = 1'b0;
                if (ss_fall_c) begin
                    state_d    = ST_SHIFT;
                    cnt_d      = '0;
                    rx_shift_d = '0;
                    miso_oe_d  = 1'b1;
                    reload_c   = 1'b1;
                end
            end
            ST_SHIFT: begin
                // SS release wins over any SCK edge seen in the same cycle.
                if (ss_rise_c) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    rx_shift_d = '0;
                    miso_d     = 1'b1;
                    miso_oe_d  = 1'b0;
                end else if (sck_rise_c) begin
                    rx_shift_d = {rx_shift_q[5:0], mosi_s};
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(7)) begin
                        rx_data_d  = {rx_shift_q, mosi_s};
                        rx_valid_d = 1'b1;
                    end
                end else if (sck_fall_c) begin
                    if (cnt_q != '0) begin
                        miso_d     = tx_shift_q[6];
                        tx_shift_d = {tx_shift_q[5:0], 1'b0};
                    end else begin
                        reload_c = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Byte boundary: take the held byte if present, else the fill byte.
        if (reload_c) begin
            if (tx_ready_q) begin
                next_byte_c = FILL_BYTE;
                underrun_d  = 1'b1;
            end else begin
                next_byte_c = hold_q;
                tx_ready_d  = 1'b1;
            end
            miso_d     = next_byte_c[7];
            tx_shift_d = next_byte_c[6:0];
        end

        // Writes land only when the holder was empty at the start of the cycle.
        if (tx_load_p && tx_ready_q) begin
            hold_d     = tx_data_p;
            tx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk210_p or negedge reset_n_p) begin
        if (!reset_n_p) begin
            state_q    <= ST_IDLE;
            sck_prev_q <= 1'b0;
            ss_prev_q  <= 1'b1;
            cnt_q      <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            hold_q     <= '0;
            tx_ready_q <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            miso_q     <= 1'b1;
            miso_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sck_prev_q <= sck_prev_d;
            ss_prev_q  <= ss_prev_d;
            cnt_q      <= cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            hold_q     <= hold_d;
            tx_ready_q <= tx_ready_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
            miso_q     <= miso_d;
            miso_oe_q  <= miso_oe_d;
        end
    end

    assign spi_miso_p    = miso_q;
    assign spi_miso_oe_p = miso_oe_q;
    assign tx_ready_p    = tx_ready_q;
    assign rx_data_p     = rx_data_q;
    assign rx_valid_p    = rx_valid_q;
    assign tx_underrun_p = underrun_q;
    assign busy_p        = (state_q == ST_SHIFT);

endmodule : sd_spi_slave_byte_transfer

// File: tb/tb_sd_spi_slave_byte_transfer.sv
// Self-checking bench: an SPI master drives byte transfers at various SCK
// rates; a byte-level model of the holding register predicts MISO bytes,
// received bytes, underrun count and tx_ready.
module tb_sd_spi_slave_byte_transfer;

    localparam logic [7:0] FILL = 8'hFF;

    logic       clk;
    logic       rst_n;
    logic       sck;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    sd_spi_slave_byte_transfer dut (
        .clk210_p      (clk),
        .reset_n_p     (rst_n),
        .spi_sck_p     (sck),
        .spi_ss_n_p    (ss_n),
        .spi_mosi_p    (mosi),
        .spi_miso_p    (miso),
        .spi_miso_oe_p (miso_oe),
        .tx_data_p     (tx_data),
        .tx_load_p     (tx_load),
        .tx_ready_p    (tx_ready),
        .rx_data_p     (rx_data),
        .rx_valid_p    (rx_valid),
        .tx_underrun_p (tx_underrun),
        .busy_p        (busy)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: holding register and expected observations.
    logic       m_full;
    logic [7:0] m_hold;
    int         m_udr;
    logic [7:0] m_rx[$];
    logic [7:0] m_out[4];

    // DUT observations.
    int         udr_cnt = 0;
    logic [7:0] got_rx[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) got_rx.push_back(rx_data);
            if (tx_underrun) udr_cnt++;
        end
    end

    // Byte boundary in the model: consume the held byte or send the fill byte.
    task automatic m_reload(output logic [7:0] b);
        if (m_full) begin
            b      = m_hold;
            m_full = 1'b0;
        end else begin
            b = FILL;
            m_udr++;
        end
    endtask

    task automatic load(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        tx_load = 1'b1;
        if (!m_full) begin
            m_full = 1'b1;
            m_hold = d;
        end
        @(negedge clk);
        tx_load = 1'b0;
        check("tx_ready_after_load", 32'(tx_ready), 32'(!m_full));
    endtask

    task automatic cmp_rx();
        check("rx_count", 32'(got_rx.size()), 32'(m_rx.size()));
        while (got_rx.size() > 0 && m_rx.size() > 0)
            check("rx_byte", 32'(got_rx.pop_front()), 32'(m_rx.pop_front()));
        got_rx.delete();
        m_rx.delete();
    endtask

    // One SS-framed transfer of nb bytes (or ab bits if ab>0, then abort).
    task automatic xfer(input int nb, input int hp, input int ab);
        logic [7:0] rd[4];
        logic [7:0] ex[4];
        logic [7:0] dummy;
        int total;
        int idx;
        int udr_snap;
        int m_snap;
        for (int i = 0; i < 4; i++) begin
            rd[i] = 8'h00;
            ex[i] = 8'h00;
        end
        m_reload(ex[0]);
        total    = (ab > 0) ? ab : nb * 8;
        udr_snap = 0;
        m_snap   = 0;
        @(negedge clk);
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
        check("busy_selected", 32'(busy), 32'd1);
        check("oe_selected", 32'(miso_oe), 32'd1);
        for (int b = 0; b < total; b++) begin
            idx  = b / 8;
            mosi = m_out[idx][7 - (b % 8)];
            repeat (hp) @(negedge clk);
            rd[idx][7 - (b % 8)] = miso;
            sck = 1'b1;
            repeat (hp) @(negedge clk);
            if (b == total - 1) begin
                udr_snap = udr_cnt;
                m_snap   = m_udr;
            end
            sck = 1'b0;
            if (b % 8 == 7) begin
                m_rx.push_back(m_out[idx]);
                if (idx < 3) m_reload(ex[idx + 1]);
                else         m_reload(dummy);
            end
        end
        repeat (8) @(negedge clk);
        ss_n = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
        check("oe_released", 32'(miso_oe), 32'd0);
        check("miso_idle", 32'(miso), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
        if (ab == 0) begin
            for (int i = 0; i < nb; i++)
                check("miso_byte", 32'(rd[i]), 32'(ex[i]));
        end else begin
            check("miso_partial", 32'(rd[0] >> (8 - ab)), 32'(ex[0] >> (8 - ab)));
        end
        check("underruns_in_xfer", 32'(udr_snap), 32'(m_snap));
        check("underruns_total", 32'(udr_cnt), 32'(m_udr));
        check("tx_ready_idle", 32'(tx_ready), 32'(!m_full));
        cmp_rx();
    endtask

    initial begin
        logic [7:0] dummy;
        rst_n   = 1'b0;
        sck     = 1'b0;
        ss_n    = 1'b1;
        mosi    = 1'b0;
        tx_data = 8'h00;
        tx_load = 1'b0;
        m_full  = 1'b0;
        m_hold  = 8'h00;
        m_udr   = 0;
        for (int i = 0; i < 4; i++) m_out[i] = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_miso", 32'(miso), 32'd1);
        check("rst_oe", 32'(miso_oe), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_underrun", 32'(tx_underrun), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Loaded byte returned while receiving 0x3C at ~5 MHz SCK.
        load(8'hA5);
        m_out[0] = 8'h3C;
        xfer(1, 21, 0);

        // No load: two bytes, fill byte returned each time.
        m_out[0] = 8'h12;
        m_out[1] = 8'h34;
        xfer(2, 6, 0);

        // Second load while not ready is ignored.
        load(8'h81);
        load(8'h55);
        m_out[0] = 8'($urandom);
        xfer(1, 5, 0);

        // Abort after four bits, then a full transfer starting at bit 7.
        load(8'h9E);
        m_out[0] = 8'($urandom);
        xfer(1, 5, 4);
        load(8'h6B);
        m_out[0] = 8'($urandom);
        xfer(1, 5, 0);

        // Asynchronous reset in the middle of a byte at the fastest SCK.
        load(8'h77);
        m_reload(dummy);
        @(negedge clk);
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            mosi = b[0];
            repeat (4) @(negedge clk);
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("arst_miso", 32'(miso), 32'd1);
        check("arst_oe", 32'(miso_oe), 32'd0);
        check("arst_ready", 32'(tx_ready), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rx_data", 32'(rx_data), 32'h00);
        check("arst_rx_valid", 32'(rx_valid), 32'd0);
        check("arst_underrun", 32'(tx_underrun), 32'd0);
        ss_n   = 1'b1;
        mosi   = 1'b0;
        m_full = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        m_out[0] = 8'hC3;
        xfer(1, 4, 0);

        // Randomised transfers, rates and load patterns.
        for (int n = 0; n < 20; n++) begin
            int nb;
            int hp;
            int ab;
            if ($urandom_range(1, 0) == 1) load(8'($urandom));
            if ($urandom_range(3, 0) == 0) load(8'($urandom));
            nb = $urandom_range(3, 1);
            hp = $urandom_range(25, 4);
            ab = ($urandom_range(4, 0) == 0) ? $urandom_range(7, 1) : 0;
            for (int i = 0; i < 4; i++) m_out[i] = 8'($urandom);
            xfer(nb, hp, ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sd_spi_slave_byte_transfer
